fnd_scan_decoder: RTL and testbench

Receive-side counterpart of the 4-digit FND scan controller. It monitors the multiplexed com/seg_7 lines, waits for each digit strobe to settle, and decodes each segment pattern back to a hex nibble. It reassembles the four nibbles into the 16-bit value being displayed. Used for on-board loopback self-check of the watch display path and as a bench monitor.

---
 rtl/fnd_scan_decoder_if.sv | 9 +
 rtl/fnd_scan_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_decoder_if.sv
// Multiplexed 4-digit FND scan lines: digit select plus segment pattern.
// The scan controller drives the master side; decoders and monitors listen on the slave side.
interface fnd_scan_decoder_if;
    logic [3:0] com;
    logic [7:0] seg_7;

    modport master (output com, output seg_7);
    modport slave  (input  com, input  seg_7);
endinterface

// File: rtl/fnd_scan_decoder.sv
// Decodes a scanned 4-digit FND back to a 16-bit value; FND_DP_CAPTURE_EN also captures dp per digit.
// Latency: 2 sync flops + SETTLE_CYCLES of stable strobe per digit, frame result one edge after the 4th capture.
// Backpressure: none; a passive monitor that only observes the scan lines.
module fnd_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_p,
    fnd_scan_decoder_if.slave    scan,
    output logic [15:0]          value,
    output logic                 value_valid,
    output logic                 value_changed,
    output logic [3:0]           dp,
    output logic                 frame_err,
    output logic                 link_lost
);
`ifdef FND_DP_CAPTURE_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
    logic unused_seg_dp;
    assign unused_seg_dp = scan.seg_7[7];
`endif
    localparam int              TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]      SMAX = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Polarity is folded in ahead of the synchronisers so reset (all zero) means "nothing selected".
    logic [3:0]    com_s1, com_n, com_prev;
    logic [SW-1:0] seg_s1, seg_n, seg_prev;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            com_s1   <= '0;
            com_n    <= '0;
            com_prev <= '0;
            seg_s1   <= '0;
            seg_n    <= '0;
            seg_prev <= '0;
        end else begin
            com_s1   <= scan.com ^ {4{COM_ACTIVE_LOW}};
            com_n    <= com_s1;
            com_prev <= com_n;
            seg_s1   <= scan.seg_7[SW-1:0] ^ {SW{SEG_ACTIVE_LOW}};
            seg_n    <= seg_s1;
            seg_prev <= seg_n;
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h00;  7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;  7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;  7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;  7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;  7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;  7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;  7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;  7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    logic       one_hot, multi_hot, seen_change;
    logic [1:0] slot;
    logic [4:0] dec;

    always_comb begin
        one_hot     = $onehot(com_n);
        multi_hot   = (com_n != 4'b0000) && !one_hot;
        seen_change = (com_n != com_prev) || (seg_n != seg_prev);
        dec         = decode(seg_n[6:0]);
        case (com_n)
            4'b0010: slot = 2'd1;
            4'b0100: slot = 2'd2;
            4'b1000: slot = 2'd3;
            default: slot = 2'd0;
        endcase
    end

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       cnt_load, cnt_inc, do_capture, do_abandon;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_load)     cnt <= 8'd1;
            else if (cnt_inc) cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        do_capture = 1'b0;
        do_abandon = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_nxt = SETTLE;
                    cnt_load  = 1'b1;
                end
            end
            SETTLE: begin
                if (multi_hot) begin
                    state_nxt  = IDLE;
                    do_abandon = 1'b1;
                end else if (!one_hot) begin
                    state_nxt = IDLE;
                end else if (seen_change) begin
                    cnt_load = 1'b1;
                end else if (cnt == SMAX) begin
                    state_nxt  = HOLD;
                    do_capture = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (multi_hot) begin
                    state_nxt  = IDLE;
                    do_abandon = 1'b1;
                end else if (com_n != com_prev) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [3:0]    nib [4];
    logic [3:0]    mask, perr;
    logic [15:0]   frame_val;
    logic [TW-1:0] tcnt;

    assign frame_val = {nib[3], nib[2], nib[1], nib[0]};
    assign link_lost = (tcnt == TMAX);

`ifdef FND_DP_CAPTURE_EN
    logic [3:0] dp_slot;
    always_ff @(posedge clk) begin
        if (reset_p) begin
            dp_slot <= '0;
            dp      <= '0;
        end else begin
            if (do_capture)
                dp_slot[slot] <= seg_n[7];
            if (mask == 4'hF && perr == 4'h0)
                dp <= dp_slot;
        end
    end
    logic dp_diff;
    assign dp_diff = (dp_slot != dp);
`else
    assign dp = 4'b0000;
    logic dp_diff;
    assign dp_diff = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_p) begin
            for (int i = 0; i < 4; i++) nib[i] <= '0;
            mask          <= '0;
            perr          <= '0;
            tcnt          <= '0;
            value         <= '0;
            value_valid   <= 1'b0;
            value_changed <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            value_valid   <= 1'b0;
            value_changed <= 1'b0;
            frame_err     <= 1'b0;

            if (do_capture)        tcnt <= '0;
            else if (tcnt != TMAX) tcnt <= tcnt + 1'b1;

            // Completion outranks abandonment so the mask is only cleared once.
            if (mask == 4'hF) begin
                mask <= '0;
                perr <= '0;
                if (perr != 4'h0) begin
                    frame_err <= 1'b1;
                end else begin
                    value         <= frame_val;
                    value_valid   <= 1'b1;
                    value_changed <= (frame_val != value) || dp_diff;
                end
            end else if (do_abandon) begin
                mask      <= '0;
                perr      <= '0;
                frame_err <= 1'b1;
            end else if (do_capture) begin
                nib[slot]  <= dec[3:0];
                perr[slot] <= dec[4];
                mask[slot] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed loopback bench for fnd_scan_decoder (active-low scan, SETTLE=16, TIMEOUT=100).
module tb_fnd_scan_decoder;
    logic        clk = 1'b0;
    logic        reset_p;
    logic [15:0] value;
    logic        value_valid, value_changed, frame_err, link_lost;
    logic [3:0]  dp;

    fnd_scan_decoder_if scan_if ();

    fnd_scan_decoder #(
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (100),
        .COM_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .scan          (scan_if.slave),
        .value         (value),
        .value_valid   (value_valid),
        .value_changed (value_changed),
        .dp            (dp),
        .frame_err     (frame_err),
        .link_lost     (link_lost)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulse monitor, sampled on the falling edge.
    int   n_valid = 0;
    int   n_err   = 0;
    logic last_changed = 1'b0;
    always @(negedge clk) begin
        if (value_valid) begin
            n_valid++;
            last_changed = value_changed;
        end
        if (frame_err) n_err++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h3F;  4'h1: seg_of = 7'h06;
            4'h2: seg_of = 7'h5B;  4'h3: seg_of = 7'h4F;
            4'h4: seg_of = 7'h66;  4'h5: seg_of = 7'h6D;
            4'h6: seg_of = 7'h7D;  4'h7: seg_of = 7'h07;
            4'h8: seg_of = 7'h7F;  4'h9: seg_of = 7'h6F;
            4'hA: seg_of = 7'h77;  4'hB: seg_of = 7'h7C;
            4'hC: seg_of = 7'h39;  4'hD: seg_of = 7'h5E;
            4'hE: seg_of = 7'h79;  default: seg_of = 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] raw_of(input logic [3:0] n, input logic dpb);
        raw_of = ~{dpb, seg_of(n)};
    endfunction

    function automatic logic [3:0] com_of(input int d);
        logic [3:0] one;
        one = 4'b0001 << d;
        com_of = ~one;
    endfunction

    task automatic drive_raw(input logic [3:0] c, input logic [7:0] s, input int hold);
        @(negedge clk);
        scan_if.com   = c;
        scan_if.seg_7 = s;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic drive_digit(input int d, input logic [15:0] v, input logic dpb);
        drive_raw(com_of(d), raw_of(v[4*d +: 4], dpb), 1000);
    endtask

    task automatic scan_frame(input logic [15:0] v, input logic [3:0] dpm);
        for (int i = 0; i < 4; i++) drive_digit(i, v, dpm[i]);
    endtask

    int   v0, e0, low_cnt;
    logic fell;

    initial begin
        reset_p       = 1'b1;
        scan_if.com   = 4'hF;
        scan_if.seg_7 = 8'hFF;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value", value, 0);
        check("rst_valid", value_valid, 0);
        check("rst_changed", value_changed, 0);
        check("rst_dp", dp, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_link_lost", link_lost, 0);

        v0 = n_valid; e0 = n_err;
        scan_frame(16'h1234, 4'b0000);
        check("f1234_valid_cnt", n_valid - v0, 1);
        check("f1234_value", value, 32'h1234);
        check("f1234_changed", last_changed, 1);
        check("f1234_err_cnt", n_err - e0, 0);

        v0 = n_valid;
        scan_frame(16'h1234, 4'b0000);
        check("rep_valid_cnt", n_valid - v0, 1);
        check("rep_changed", last_changed, 0);

        v0 = n_valid;
        scan_frame(16'h1235, 4'b0000);
        check("f1235_value", value, 32'h1235);
        check("f1235_changed", last_changed, 1);

        // Digit 0 pattern never stable for 16 cycles.
        v0 = n_valid; e0 = n_err;
        for (int k = 0; k < 125; k++)
            drive_raw(com_of(0), raw_of((k % 2 == 0) ? 4'h5 : 4'h6, 1'b0), 8);
        check("toggle_valid_cnt", n_valid - v0, 0);
        check("toggle_err_cnt", n_err - e0, 0);
        v0 = n_valid;
        scan_frame(16'h1235, 4'b0000);
        check("clean_valid_cnt", n_valid - v0, 1);
        check("clean_value", value, 32'h1235);
        check("clean_changed", last_changed, 0);

        // Blank pattern on digit 2.
        v0 = n_valid; e0 = n_err;
        drive_digit(0, 16'h1235, 1'b0);
        drive_digit(1, 16'h1235, 1'b0);
        drive_raw(com_of(2), 8'hFF, 1000);
        drive_digit(3, 16'h1235, 1'b0);
        check("perr_err_cnt", n_err - e0, 1);
        check("perr_valid_cnt", n_valid - v0, 0);
        check("perr_value_held", value, 32'h1235);

        // Two digits selected mid-frame.
        v0 = n_valid; e0 = n_err;
        drive_digit(0, 16'h0A5F, 1'b0);
        drive_digit(1, 16'h0A5F, 1'b0);
        drive_raw(4'b1100, raw_of(4'h8, 1'b0), 50);
        check("mh_err_cnt", n_err - e0, 1);
        check("mh_valid_cnt", n_valid - v0, 0);
        drive_digit(2, 16'h0A5F, 1'b0);
        drive_digit(3, 16'h0A5F, 1'b0);
        check("mh_mask_cleared", n_valid - v0, 0);
        drive_digit(0, 16'h0A5F, 1'b0);
        drive_digit(1, 16'h0A5F, 1'b0);
        check("f0a5f_valid_cnt", n_valid - v0, 1);
        check("f0a5f_value", value, 32'h0A5F);
        check("f0a5f_changed", last_changed, 1);
        check("f0a5f_err_cnt", n_err - e0, 1);

        // Timeout: stop scanning, then one capture, then silence.
        check("link_lost_idle", link_lost, 1);
        drive_raw(4'hF, 8'hFF, 50);
        drive_raw(com_of(0), raw_of(4'hF, 1'b0), 1);
        fell = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!link_lost) begin
                fell = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("link_lost_cleared", fell, 1);
        low_cnt = 0;
        while (fell && !link_lost && low_cnt < 300) begin
            low_cnt++;
            @(negedge clk);
        end
        check("link_low_cycles", low_cnt, 100);
        check("link_lost_reassert", link_lost, 1);

        // dp lit on digit 2 only.
        v0 = n_valid; e0 = n_err;
        scan_frame(16'h0A5F, 4'b0100);
        check("dp_valid_cnt", n_valid - v0, 1);
        check("dp_value", value, 32'h0A5F);
`ifdef FND_DP_CAPTURE_EN
        check("dp_bits", dp, 32'h4);
        check("dp_changed", last_changed, 1);
`else
        check("dp_bits", dp, 32'h0);
        check("dp_changed", last_changed, 0);
`endif
        check("dp_err_cnt", n_err - e0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
